// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I ID stage: decode, register file, load-use hazard, ID/EX register.
// Optional macro REGFILE_BYPASS_EN makes register-file reads write-first against the WB port.
module decode_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           Ins_D,
    input  logic [ADDR_WIDTH-1:0] PC_D,
    input  logic [ADDR_WIDTH-1:0] PC_4D,
    input  logic                  PCSrc_E,
    input  logic                  RegWrite_W,
    input  logic [4:0]            Rd_W,
    input  logic [ADDR_WIDTH-1:0] Result_W,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic [ADDR_WIDTH-1:0] RD1_E,
    output logic [ADDR_WIDTH-1:0] RD2_E,
    output logic [ADDR_WIDTH-1:0] Imm_Ext_E,
    output logic [ADDR_WIDTH-1:0] PC_E,
    output logic [ADDR_WIDTH-1:0] PC_4E,
    output logic [4:0]            Rs1_E,
    output logic [4:0]            Rs2_E,
    output logic [4:0]            Rd_E,
    output logic                  RegWrite_E,
    output logic                  MemWrite_E,
    output logic                  Jump_E,
    output logic                  Branch_E,
    output logic                  ALUSrc_E,
    output logic [1:0]            ResultSrc_E,
    output logic [2:0]            ALUControl_E
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [6:0]            w_opcode;
    logic [4:0]            w_rs1, w_rs2, w_rd;
    logic                  w_reg_write, w_mem_write, w_jump, w_branch, w_alu_src;
    logic [1:0]            w_result_src;
    logic [2:0]            w_alu_ctl, w_alu_func;
    logic [ADDR_WIDTH-1:0] w_imm, w_rd1, w_rd2;
    logic                  w_stall;

    logic [ADDR_WIDTH-1:0] r_regs [REG_COUNT];

    assign w_opcode = Ins_D[6:0];
    assign w_rd     = Ins_D[11:7];
    assign w_rs1    = Ins_D[19:15];
    assign w_rs2    = Ins_D[24:20];

    // sub is only legal for R-type; addi with imm[10]=1 must stay an add
    always_comb begin
        w_alu_func = 3'b000;
        case (Ins_D[14:12])
            3'b000:  w_alu_func = (w_opcode == OP_R && Ins_D[30]) ? 3'b001 : 3'b000;
            3'b010:  w_alu_func = 3'b101;
            3'b110:  w_alu_func = 3'b011;
            3'b111:  w_alu_func = 3'b010;
            default: w_alu_func = 3'b000;
        endcase
    end

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_jump       = 1'b0;
        w_branch     = 1'b0;
        w_alu_src    = 1'b0;
        w_result_src = 2'b00;
        w_alu_ctl    = 3'b000;
        w_imm        = '0;
        case (w_opcode)
            OP_LW: begin
                w_imm        = {{(ADDR_WIDTH-12){Ins_D[31]}}, Ins_D[31:20]};
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b01;
            end
            OP_SW: begin
                w_imm       = {{(ADDR_WIDTH-12){Ins_D[31]}}, Ins_D[31:25], Ins_D[11:7]};
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_R: begin
                w_reg_write = 1'b1;
                w_alu_ctl   = w_alu_func;
            end
            OP_I: begin
                w_imm       = {{(ADDR_WIDTH-12){Ins_D[31]}}, Ins_D[31:20]};
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_ctl   = w_alu_func;
            end
            OP_BEQ: begin
                w_imm     = {{(ADDR_WIDTH-12){Ins_D[31]}}, Ins_D[7], Ins_D[30:25], Ins_D[11:8], 1'b0};
                w_branch  = 1'b1;
                w_alu_ctl = 3'b001;
            end
            OP_JAL: begin
                w_imm        = {{(ADDR_WIDTH-20){Ins_D[31]}}, Ins_D[19:12], Ins_D[20], Ins_D[30:21], 1'b0};
                w_jump       = 1'b1;
                w_reg_write  = 1'b1;
                w_result_src = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (RegWrite_W && Rd_W != 5'd0) begin
            r_regs[Rd_W] <= Result_W;
        end
    end

    always_comb begin
        w_rd1 = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
        w_rd2 = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite_W && Rd_W != 5'd0 && Rd_W == w_rs1) w_rd1 = Result_W;
        if (RegWrite_W && Rd_W != 5'd0 && Rd_W == w_rs2) w_rd2 = Result_W;
`endif
    end

    assign w_stall     = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                         ((Rd_E == w_rs1) || (Rd_E == w_rs2));
    assign PC_Write    = ~w_stall;
    assign IF_ID_Write = ~w_stall;

    // flush and load-use stall both insert a fully zeroed bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst || PCSrc_E || w_stall) begin
            RD1_E        <= '0;
            RD2_E        <= '0;
            Imm_Ext_E    <= '0;
            PC_E         <= '0;
            PC_4E        <= '0;
            Rs1_E        <= '0;
            Rs2_E        <= '0;
            Rd_E         <= '0;
            RegWrite_E   <= 1'b0;
            MemWrite_E   <= 1'b0;
            Jump_E       <= 1'b0;
            Branch_E     <= 1'b0;
            ALUSrc_E     <= 1'b0;
            ResultSrc_E  <= 2'b00;
            ALUControl_E <= 3'b000;
        end else begin
            RD1_E        <= w_rd1;
            RD2_E        <= w_rd2;
            Imm_Ext_E    <= w_imm;
            PC_E         <= PC_D;
            PC_4E        <= PC_4D;
            Rs1_E        <= w_rs1;
            Rs2_E        <= w_rs2;
            Rd_E         <= w_rd;
            RegWrite_E   <= w_reg_write;
            MemWrite_E   <= w_mem_write;
            Jump_E       <= w_jump;
            Branch_E     <= w_branch;
            ALUSrc_E     <= w_alu_src;
            ResultSrc_E  <= w_result_src;
            ALUControl_E <= w_alu_ctl;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed scoreboard bench for decode_stage.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Ins_D = '0, PC_D = '0, PC_4D = '0, Result_W = '0;
    logic        PCSrc_E = 1'b0, RegWrite_W = 1'b0;
    logic [4:0]  Rd_W = '0;
    logic        PC_Write, IF_ID_Write;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PC_4E;
    logic [4:0]  Rs1_E, Rs2_E, Rd_E;
    logic        RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E;
    logic [1:0]  ResultSrc_E;
    logic [2:0]  ALUControl_E;

    decode_stage dut (
        .clk(clk), .rst(rst), .Ins_D(Ins_D), .PC_D(PC_D), .PC_4D(PC_4D),
        .PCSrc_E(PCSrc_E), .RegWrite_W(RegWrite_W), .Rd_W(Rd_W), .Result_W(Result_W),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E), .PC_4E(PC_4E),
        .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .Jump_E(Jump_E),
        .Branch_E(Branch_E), .ALUSrc_E(ALUSrc_E), .ResultSrc_E(ResultSrc_E),
        .ALUControl_E(ALUControl_E)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw, j, b, as;
        logic [1:0]  rs;
        logic [2:0]  alu;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] old_x8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t x);
        chk({tag, ".RD1_E"}, RD1_E, x.rd1);
        chk({tag, ".RD2_E"}, RD2_E, x.rd2);
        chk({tag, ".Imm_Ext_E"}, Imm_Ext_E, x.imm);
        chk({tag, ".PC_E"}, PC_E, x.pc);
        chk({tag, ".PC_4E"}, PC_4E, x.pc4);
        chk({tag, ".Rs1_E"}, {27'd0, Rs1_E}, {27'd0, x.rs1});
        chk({tag, ".Rs2_E"}, {27'd0, Rs2_E}, {27'd0, x.rs2});
        chk({tag, ".Rd_E"}, {27'd0, Rd_E}, {27'd0, x.rd});
        chk({tag, ".ctl"}, {27'd0, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E},
            {27'd0, x.rw, x.mw, x.j, x.b, x.as});
        chk({tag, ".ResultSrc_E"}, {30'd0, ResultSrc_E}, {30'd0, x.rs});
        chk({tag, ".ALUControl_E"}, {29'd0, ALUControl_E}, {29'd0, x.alu});
    endtask

    function automatic exp_t base(input logic [31:0] pc);
        exp_t x;
        x = '0;
        x.pc  = pc;
        x.pc4 = pc + 32'd4;
        return x;
    endfunction

    // drive one ID cycle, check hazard outputs, push expectation, then pop/compare after the edge
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                        input logic pcsrc, input logic wbe, input logic [4:0] wrd,
                        input logic [31:0] wres, input logic exp_pcw, input exp_t x);
        exp_t got;
        @(negedge clk);
        Ins_D = ins; PC_D = pc; PC_4D = pc + 32'd4; PCSrc_E = pcsrc;
        RegWrite_W = wbe; Rd_W = wrd; Result_W = wres;
        q.push_back(x);
        #1;
        chk({tag, ".PC_Write"}, {31'd0, PC_Write}, {31'd0, exp_pcw});
        chk({tag, ".IF_ID_Write"}, {31'd0, IF_ID_Write}, {31'd0, exp_pcw});
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk_out(tag, got);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", base(32'd0) & ~exp_t'({32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 26'd0}));
        chk("reset.PC_Write", {31'd0, PC_Write}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        step("nop_wb_x1", 32'h0, 32'h100, 0, 1, 5'd1, 32'h11111111, 1, base(32'h100));

        e = base(32'h104); e.imm = 32'hFFFFFFFD; e.as = 1; e.rw = 1; e.rd = 5; e.rs2 = 29;
        step("addi", 32'hFFD00293, 32'h104, 0, 0, 0, 0, 1, e);

        e = base(32'h108); e.rw = 1; e.as = 1; e.rs = 2'b01; e.rd = 6; e.rs1 = 5;
        step("lw", 32'h0002A303, 32'h108, 0, 0, 0, 0, 1, e);

        step("load_use_bubble", 32'h001303B3, 32'h10C, 0, 0, 0, 0, 0, base(32'h0) & '0);

        e = base(32'h10C); e.rw = 1; e.rs1 = 6; e.rs2 = 1; e.rd = 7; e.rd2 = 32'h11111111;
        step("add_after_stall", 32'h001303B3, 32'h10C, 0, 0, 0, 0, 1, e);

        e = base(32'h110); e.rw = 1; e.rs1 = 1; e.rs2 = 1; e.rd = 9; e.alu = 3'b001;
        e.rd1 = 32'h11111111; e.rd2 = 32'h11111111;
        step("sub", 32'h401084B3, 32'h110, 0, 0, 0, 0, 1, e);

        step("sw_flush", 32'h00102223, 32'h114, 1, 0, 0, 0, 1, base(32'h0) & '0);

        e = base(32'h114); e.mw = 1; e.as = 1; e.imm = 4; e.rs2 = 1; e.rd = 4; e.rd2 = 32'h11111111;
        step("sw", 32'h00102223, 32'h114, 0, 0, 0, 0, 1, e);

`ifdef REGFILE_BYPASS_EN
        old_x8 = 32'hDEADBEEF;
`else
        old_x8 = 32'h0;
`endif
        e = base(32'h118); e.rw = 1; e.rs1 = 8; e.rd = 10; e.alu = 3'b011; e.rd1 = old_x8;
        step("wb_same_cycle_x8", 32'h00046533, 32'h118, 0, 1, 5'd8, 32'hDEADBEEF, 1, e);
        e.rd1 = 32'hDEADBEEF;
        step("reread_x8", 32'h00046533, 32'h118, 0, 0, 0, 0, 1, e);

        step("wb_x0", 32'h0, 32'h11C, 0, 1, 5'd0, 32'h1234, 1, base(32'h11C));

        e = base(32'h120); e.rw = 1; e.rs2 = 8; e.rd = 11; e.alu = 3'b010; e.rd2 = 32'hDEADBEEF;
        step("and_read_x0", 32'h008075B3, 32'h120, 0, 0, 0, 0, 1, e);

        e = base(32'h124); e.b = 1; e.alu = 3'b001; e.imm = 32'hFFFFFFF8; e.rs1 = 1; e.rs2 = 1;
        e.rd = 25; e.rd1 = 32'h11111111; e.rd2 = 32'h11111111;
        step("beq", 32'hFE108CE3, 32'h124, 0, 0, 0, 0, 1, e);

        e = base(32'h128); e.j = 1; e.rw = 1; e.rs = 2'b10; e.imm = 32'd16; e.rd = 1; e.rs2 = 16;
        step("jal", 32'h010000EF, 32'h128, 0, 0, 0, 0, 1, e);

        e = base(32'h12C); e.rw = 1; e.as = 1; e.alu = 3'b101; e.imm = 5; e.rs1 = 1; e.rs2 = 5;
        e.rd = 12; e.rd1 = 32'h11111111;
        step("slti", 32'h0050A613, 32'h12C, 0, 0, 0, 0, 1, e);

        e = base(32'h130); e.rw = 1; e.as = 1; e.rs = 2'b01; e.rd = 13; e.rs1 = 1; e.rd1 = 32'h11111111;
        step("lw_x13", 32'h0000A683, 32'h130, 0, 0, 0, 0, 1, e);
        step("flush_and_stall", 32'h00068733, 32'h134, 1, 0, 0, 0, 0, base(32'h0) & '0);

        step("lw_x13_again", 32'h0000A683, 32'h130, 0, 0, 0, 0, 1, e);
        @(negedge clk);
        Ins_D = 32'h00068733; PC_D = 32'h134; PC_4D = 32'h138; PCSrc_E = 0; RegWrite_W = 0;
        #1;
        chk("midstall.PC_Write", {31'd0, PC_Write}, 32'd0);
        rst = 1'b1;
        #1;
        chk_out("midstall_reset", base(32'h0) & '0);
        chk("midstall_reset.PC_Write", {31'd0, PC_Write}, 32'd1);
        chk("midstall_reset.IF_ID_Write", {31'd0, IF_ID_Write}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        e = base(32'h140); e.rw = 1; e.rs1 = 1; e.rs2 = 8; e.rd = 14;
        step("read_after_reset", 32'h00808733, 32'h140, 0, 0, 0, 0, 1, e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
